uart_cmd_ctrl: RTL



---
 rtl/uart_cmd_pkg.sv | 17 +
 rtl/uart_cmd_timeout.sv | 30 +++
 rtl/uart_cmd_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the framed UART command controller.
package uart_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA,
        CSUM
    } state_t;

    localparam logic [7:0] CMD_SET_DISP = 8'h01;
    localparam logic [7:0] CMD_SET_LED  = 8'h02;
    localparam logic [7:0] CMD_SET_BOTH = 8'h03;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte timeout: down-counter reloaded by clear, expire when it has run out.
module uart_cmd_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYCLES - 1);

    // remaining == LOAD is the "zero elapsed cycles" state; it holds at zero so it never wraps
    logic [CW-1:0] remaining;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remaining <= LOAD;
        end else if (clear) begin
            remaining <= LOAD;
        end else if (enable && remaining != '0) begin
            remaining <= remaining - CW'(1);
        end
    end

    assign expire = enable && (remaining == '0);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Framed command parser (SYNC, CMD, DATA, CSUM) driving the display byte and LED nibble.
// Optional UART_CMD_STATS_EN adds saturating good/error frame counters.
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE      = SYNC_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 250000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_rx_byte,
    input  logic       i_rx_valid,
    output logic [7:0] o_disp_byte,
    output logic [3:0] o_led,
    output logic       o_update,
    output logic       o_frame_err,
    output logic       o_busy
`ifdef UART_CMD_STATS_EN
    ,
    output logic [7:0] o_good_count,
    output logic [7:0] o_err_count
`endif
);

    state_t     state, state_n;
    logic [7:0] cmd, cmd_n;
    logic [7:0] data, data_n;
    logic [7:0] disp_n;
    logic [3:0] led_n;
    logic       upd_n, err_n;
    logic       expire;

    uart_cmd_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk    (i_clk),
        .rst    (i_rst),
        .clear  (i_rx_valid || state == IDLE),
        .enable (state != IDLE),
        .expire (expire)
    );

    always_comb begin
        state_n = state;
        cmd_n   = cmd;
        data_n  = data;
        disp_n  = o_disp_byte;
        led_n   = o_led;
        upd_n   = 1'b0;
        err_n   = 1'b0;
        // a byte arriving on the expiry cycle takes priority over the timeout
        if (i_rx_valid) begin
            unique case (state)
                IDLE: if (i_rx_byte == SYNC_BYTE) state_n = CMD;
                CMD: begin
                    cmd_n = i_rx_byte;
                    if (i_rx_byte inside {CMD_SET_DISP, CMD_SET_LED, CMD_SET_BOTH}) begin
                        state_n = DATA;
                    end else if (i_rx_byte != SYNC_BYTE) begin
                        err_n   = 1'b1;
                        state_n = IDLE;
                    end
                end
                DATA: begin
                    data_n  = i_rx_byte;
                    state_n = CSUM;
                end
                CSUM: begin
                    state_n = IDLE;
                    if (i_rx_byte != (cmd ^ data) || (cmd == CMD_SET_LED && data[7:4] != 4'h0)) begin
                        err_n = 1'b1;
                    end else begin
                        upd_n = 1'b1;
                        if (cmd != CMD_SET_LED)  disp_n = data;
                        if (cmd != CMD_SET_DISP) led_n  = data[3:0];
                    end
                end
                default: state_n = IDLE;
            endcase
        end else if (expire) begin
            err_n   = 1'b1;
            state_n = IDLE;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            cmd         <= 8'h00;
            data        <= 8'h00;
            o_disp_byte <= 8'h00;
            o_led       <= 4'h0;
            o_update    <= 1'b0;
            o_frame_err <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            state       <= state_n;
            cmd         <= cmd_n;
            data        <= data_n;
            o_disp_byte <= disp_n;
            o_led       <= led_n;
            o_update    <= upd_n;
            o_frame_err <= err_n;
            o_busy      <= (state_n != IDLE);
        end
    end

`ifdef UART_CMD_STATS_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_good_count <= 8'h00;
            o_err_count  <= 8'h00;
        end else begin
            if (upd_n && o_good_count != 8'hFF) o_good_count <= o_good_count + 8'd1;
            if (err_n && o_err_count != 8'hFF)  o_err_count  <= o_err_count + 8'd1;
        end
    end
`endif

endmodule
